motor_ramp_ctrl: RTL and testbench

//   Parametrised soft-start/soft-stop ramp controller for the motor-speed FSM path.
//   - Steps an N-level speed output up or down, one level at a time.
//   - Timing comes from an internal clock-enable prescaler, so there is no derived clock.
//   - Adds ramp-down, an emergency stop, a programmable slow level and status outputs.
//   - Sits behind the tt_um top: commands come from ui_in, the level outputs drive uo_out.

---
 rtl/motor_ramp_ctrl.sv | 114 +++++++++++
 tb/tb_motor_ramp_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// Soft-start/soft-stop ramp controller: steps an N-level speed output toward a
// commanded target on a prescaled tick, with emergency stop and clock-enable freeze.
module motor_ramp_ctrl #(
   parameter int CLK_DIV     = 4,
   parameter int DWELL_TICKS = 2,
   parameter int N_LEVELS    = 3,
   parameter int SLOW_LEVEL  = 2,
   localparam int LW         = $clog2(N_LEVELS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                fast,
   input  logic                slow,
   input  logic                stop,
   output logic [LW-1:0]       level,
   output logic [N_LEVELS-1:0] level_oh,
   output logic                at_target,
   output logic [1:0]          state
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

   localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
   localparam logic [LW-1:0] FAST_T     = LW'(N_LEVELS);
   localparam logic [LW-1:0] SLOW_T     = LW'(SLOW_LEVEL);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      RAMP_UP   = 2'b01,
      HOLD      = 2'b10,
      RAMP_DOWN = 2'b11
   } state_t;

   state_t        state_r;
   logic [LW-1:0] level_r;
   logic [LW-1:0] target_r;
   logic [PW-1:0] pre_r;
   logic [DW-1:0] dwell_r;

   logic          tick;
   logic          ramping;
   logic          cmd_valid;
   logic          cmd_new;
   logic [LW-1:0] cmd_t;
   logic [LW-1:0] step_level;

   always_comb begin
      tick       = (pre_r == PRE_LAST);
      ramping    = (state_r == RAMP_UP) || (state_r == RAMP_DOWN);
      cmd_valid  = fast || slow;
      cmd_t      = fast ? FAST_T : SLOW_T;
      cmd_new    = cmd_valid && (cmd_t != target_r);
      step_level = (state_r == RAMP_UP) ? (level_r + LW'(1)) : (level_r - LW'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         level_r  <= '0;
         target_r <= '0;
         pre_r    <= '0;
         dwell_r  <= '0;
      end else if (ena) begin
         if (stop) begin
            state_r  <= IDLE;
            level_r  <= '0;
            target_r <= '0;
            pre_r    <= '0;
            dwell_r  <= '0;
         end else if (cmd_new) begin
            // Redirect from wherever the level currently is; timing restarts at this edge.
            target_r <= cmd_t;
            pre_r    <= '0;
            dwell_r  <= '0;
            if (cmd_t > level_r)
               state_r <= RAMP_UP;
            else if (cmd_t < level_r)
               state_r <= RAMP_DOWN;
            else
               state_r <= HOLD;
         end else begin
            pre_r <= tick ? '0 : (pre_r + PW'(1));
            if (ramping) begin
               if (tick) begin
                  if (dwell_r == DWELL_LAST) begin
                     dwell_r <= '0;
                     level_r <= step_level;
                     if (step_level == target_r)
                        state_r <= (target_r == '0) ? IDLE : HOLD;
                  end else begin
                     dwell_r <= dwell_r + DW'(1);
                  end
               end
            end else begin
               dwell_r <= '0;
            end
         end
      end
   end

   always_comb begin
      level_oh = '0;
      for (int k = 0; k < N_LEVELS; k++)
         level_oh[k] = (level_r == LW'(k + 1));
   end

   assign level     = level_r;
   assign state     = state_r;
   assign at_target = (level_r == target_r) && ((state_r == IDLE) || (state_r == HOLD));

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: event-level speed model checked every cycle, plus
// directed scenarios with literal expectations at hand-computed edges.
module tb_motor_ramp_ctrl;

   localparam int CLK_DIV     = 4;
   localparam int DWELL_TICKS = 2;
   localparam int N_LEVELS    = 3;
   localparam int SLOW_LEVEL  = 2;
   localparam int LW          = $clog2(N_LEVELS + 1);
   localparam int STEP        = CLK_DIV * DWELL_TICKS;

   logic                clk;
   logic                rst_n;
   logic                ena;
   logic                fast;
   logic                slow;
   logic                stop;
   logic [LW-1:0]       level;
   logic [N_LEVELS-1:0] level_oh;
   logic                at_target;
   logic [1:0]          state;

   int vectors    = 0;
   int miscompares = 0;

   motor_ramp_ctrl #(
      .CLK_DIV    (CLK_DIV),
      .DWELL_TICKS(DWELL_TICKS),
      .N_LEVELS   (N_LEVELS),
      .SLOW_LEVEL (SLOW_LEVEL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .fast     (fast),
      .slow     (slow),
      .stop     (stop),
      .level    (level),
      .level_oh (level_oh),
      .at_target(at_target),
      .state    (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: level walks toward target one step every STEP enabled edges after accept/step
   int m_level;
   int m_target;
   int m_cnt;
   int m_cmd;
   assign m_cmd = fast ? N_LEVELS : SLOW_LEVEL;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_level  <= 0;
         m_target <= 0;
         m_cnt    <= 0;
      end else if (ena) begin
         if (stop) begin
            m_level  <= 0;
            m_target <= 0;
            m_cnt    <= 0;
         end else if ((fast || slow) && (m_cmd != m_target)) begin
            m_target <= m_cmd;
            m_cnt    <= 0;
         end else if (m_level != m_target) begin
            if (m_cnt == STEP - 1) begin
               m_level <= (m_level < m_target) ? m_level + 1 : m_level - 1;
               m_cnt   <= 0;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   function automatic int exp_state(int lv, int tg);
      if (lv == tg) return (tg == 0) ? 0 : 2;
      return (lv < tg) ? 1 : 3;
   endfunction

   function automatic int exp_oh(int lv);
      return (lv == 0) ? 0 : (1 << (lv - 1));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // scoreboard compare on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         check("model_level", int'(level), m_level);
         check("model_level_oh", int'(level_oh), exp_oh(m_level));
         check("model_state", int'(state), exp_state(m_level, m_target));
         check("model_at_target", int'(at_target), (m_level == m_target) ? 1 : 0);
      end
   end

   // driver tasks: inputs change 1ns after a rising edge
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic f, input logic s, input logic p);
      fast = f; slow = s; stop = p;
      edges(1);
      fast = 1'b0; slow = 1'b0; stop = 1'b0;
   endtask

   task automatic expect_out(input string name, input int lv, input int oh, input int st, input int at);
      check({name, "_level"}, int'(level), lv);
      check({name, "_oh"}, int'(level_oh), oh);
      check({name, "_state"}, int'(state), st);
      check({name, "_at_target"}, int'(at_target), at);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; fast = 1'b0; slow = 1'b0; stop = 1'b0;
      edges(3);
      rst_n = 1'b1;

      // 1: idle after reset
      expect_out("reset", 0, 0, 0, 1);
      edges(50);
      expect_out("idle50", 0, 0, 0, 1);

      // 2: soft start to full speed
      pulse(1'b1, 1'b0, 1'b0);                         // now at E0
      expect_out("fast_e0", 0, 0, 1, 0);
      edges(7);  expect_out("fast_e7", 0, 0, 1, 0);
      edges(1);  expect_out("fast_e8", 1, 1, 1, 0);
      edges(8);  expect_out("fast_e16", 2, 2, 1, 0);
      edges(8);  expect_out("fast_e24", 3, 4, 2, 1);
      edges(10); expect_out("fast_hold", 3, 4, 2, 1);

      // 3: slow from full speed
      pulse(1'b0, 1'b1, 1'b0);
      expect_out("slow_e0", 3, 4, 3, 0);
      edges(7);  expect_out("slow_e7", 3, 4, 3, 0);
      edges(1);  expect_out("slow_e8", 2, 2, 2, 1);
      edges(12); expect_out("slow_hold", 2, 2, 2, 1);

      // 4: stop mid-ramp
      pulse(1'b0, 1'b0, 1'b1);
      expect_out("stop_clr", 0, 0, 0, 1);
      pulse(1'b1, 1'b0, 1'b0);
      edges(8);  expect_out("mid_e8", 1, 1, 1, 0);
      edges(1);
      stop = 1'b1;
      edges(1);  expect_out("stop_e10", 0, 0, 0, 1);
      edges(5);  expect_out("stop_held", 0, 0, 0, 1);
      stop = 1'b0;
      edges(4);

      // 5: fast+slow together, then a repeated fast mid-ramp
      pulse(1'b1, 1'b1, 1'b0);
      expect_out("both_e0", 0, 0, 1, 0);
      edges(5);
      pulse(1'b1, 1'b0, 1'b0);                         // sampled at E0+6, same target
      edges(1);  expect_out("rep_e7", 0, 0, 1, 0);
      edges(1);  expect_out("rep_e8", 1, 1, 1, 0);
      edges(8);  expect_out("rep_e16", 2, 2, 1, 0);
      edges(8);  expect_out("rep_e24", 3, 4, 2, 1);

      // redirect: slow mid-ramp-down? go 0->3 then slow at level 2 while rising
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      edges(16); expect_out("redir_pre", 2, 2, 1, 0);
      pulse(1'b0, 1'b1, 1'b0);
      expect_out("redir_hold", 2, 2, 2, 1);
      edges(20); expect_out("redir_stay", 2, 2, 2, 1);

      // 6: ena freeze mid-ramp delays the step by 20 cycles
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      edges(3);
      ena = 1'b0;
      fast = 1'b0; slow = 1'b1;                        // ignored while frozen
      edges(20);
      expect_out("frozen", 0, 0, 1, 0);
      slow = 1'b0;
      ena = 1'b1;
      edges(4);  expect_out("ena_e27", 0, 0, 1, 0);
      edges(1);  expect_out("ena_e28", 1, 1, 1, 0);
      edges(3);

      // asynchronous reset mid-ramp, no clock edge in between
      expect_out("pre_rst", 1, 1, 1, 0);
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 0, 0, 0, 1);
      edges(3);
      rst_n = 1'b1;
      edges(2);
      expect_out("post_rst", 0, 0, 0, 1);

      // slow from off ramps up to SLOW_LEVEL
      pulse(1'b0, 1'b1, 1'b0);
      edges(16); expect_out("slow_up", 2, 2, 2, 1);
      edges(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
